// File: rtl/request_queue.sv
// Parameterised first-word fall-through request queue built on a circular buffer.
// Define REQ_QUEUE_BYPASS_EN to let a word offered to an empty queue appear on the output in the same cycle.
module request_queue #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned DEPTH   = 4,
   parameter logic [31:0] RST_VAL = 32'h1C00_0000
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_hold;

   logic             w_empty;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic             w_store;
   logic             w_deq;
   logic [WIDTH-1:0] w_head;

   assign w_empty = (r_count == CW'(0));
   assign w_full  = (r_count == CW'(DEPTH));

   // in_ready depends only on registered occupancy, so a same-cycle pop never frees a full queue.
   assign in_ready = !w_full;
   assign count    = r_count;

`ifdef REQ_QUEUE_BYPASS_EN
   assign out_valid = !w_empty || in_valid;
   assign w_head    = !w_empty ? r_mem[r_rd_ptr] : (in_valid ? in_data : r_hold);
   // A word popped while the queue is empty passes straight through and is never stored.
   assign w_store   = w_push && !(w_empty && out_ready);
`else
   assign out_valid = !w_empty;
   assign w_head    = !w_empty ? r_mem[r_rd_ptr] : r_hold;
   assign w_store   = w_push;
`endif

   assign out_data = w_head;
   assign w_push   = in_valid && in_ready;
   assign w_pop    = out_valid && out_ready;
   assign w_deq    = w_pop && !w_empty;

   // Pointers, occupancy and the last-popped hold register; reset and flush share one clear path.
   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         r_rd_ptr <= AW'(0);
         r_wr_ptr <= AW'(0);
         r_count  <= CW'(0);
         r_hold   <= RST_W;
      end else begin
         if (w_store) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_deq)   r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_store && !w_deq)      r_count <= r_count + CW'(1);
         else if (!w_store && w_deq) r_count <= r_count - CW'(1);
         if (w_pop) r_hold <= w_head;
      end
   end

   // Storage array is deliberately left without reset.
   always_ff @(posedge clk) begin
      if (rstn && !flush && w_store) r_mem[r_wr_ptr] <= in_data;
   end

endmodule

// File: tb/tb_request_queue.sv
// Randomised scoreboard bench for request_queue with directed fill, wrap, flush and bypass phases.
// Follows REQ_QUEUE_BYPASS_EN so the same bench covers both builds.
module tb_request_queue;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RST   = 32'h1C00_0000;

   logic              clk = 1'b0;
   logic              rstn;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_data;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_data;
   logic [2:0]        count;

   request_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RST)) dut (
      .clk(clk), .rstn(rstn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count)
   );

   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic [31:0] sb_q[$];
   logic [31:0] hold_word = RST;
   bit          model_ok  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Monitor: compare the DUT against the reference queue mid-cycle, then advance the queue for the coming edge.
   always @(negedge clk) begin
      logic        e_valid;
      logic        e_ready;
      logic [31:0] e_data;
      bit          bypass_now;
      int          sz;
      sz = sb_q.size();
      e_ready = (sz != DEPTH);
`ifdef REQ_QUEUE_BYPASS_EN
      bypass_now = (sz == 0) && in_valid;
`else
      bypass_now = 1'b0;
`endif
      e_valid = (sz != 0) || bypass_now;
      e_data  = (sz != 0) ? sb_q[0] : (bypass_now ? in_data : hold_word);
      if (model_ok) begin
         check("count",     32'(count),     32'(sz));
         check("in_ready",  32'(in_ready),  32'(e_ready));
         check("out_valid", 32'(out_valid), 32'(e_valid));
         check("out_data",  out_data,       e_data);
      end
      if (!rstn) begin
         sb_q.delete();
         hold_word = RST;
         model_ok  = 1'b1;
      end else if (model_ok) begin
         if (flush) begin
            sb_q.delete();
            hold_word = RST;
         end else if (bypass_now && out_ready) begin
            hold_word = in_data;
         end else begin
            if (e_valid && out_ready) hold_word = sb_q.pop_front();
            if (in_valid && e_ready)  sb_q.push_back(in_data);
         end
      end
   end

   task automatic drive(input logic rv, input logic fl, input logic iv,
                        input logic [31:0] d, input logic ordy);
      @(posedge clk);
      #1;
      rstn = rv; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
   endtask

   initial begin
      rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

      // Fill to full, offer one extra word, then drain.
      for (int i = 1; i <= 5; i++) drive(1'b1, 1'b0, 1'b1, 32'(i * 16), 1'b0);
      for (int i = 0; i < 5; i++)  drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

      // Hold two entries while streaming through the pointer wrap.
      drive(1'b1, 1'b0, 1'b1, 32'h100, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 32'h101, 1'b0);
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b1, 32'h200 + 32'(i), 1'b1);

      // Flush beats a concurrent push and pop.
      drive(1'b1, 1'b0, 1'b1, 32'h300, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 32'hDEAD, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

      // Offer a word to an empty queue with the consumer ready.
      drive(1'b1, 1'b0, 1'b1, 32'hABCD, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

      for (int i = 0; i < 600; i++) begin
         drive(($urandom % 100) != 0, ($urandom % 40) == 0, 1'($urandom % 2),
               $urandom, (($urandom % 3) != 0));
      end

      // Mid-transfer reset must drop everything.
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 32'h500 + 32'(i), 1'b0);
      drive(1'b0, 1'b0, 1'b1, 32'h5FF, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/request_queue.md
REQUEST_QUEUE -- requirements
Module: request_queue

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the request word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of entries, a power of two of at least 2.
REQ-003 The block SHALL have parameter RST_VAL, default 32'h1C00_0000, meaning the out_data value after reset or flush, truncated or zero-extended to WIDTH.
REQ-004 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-005 The block SHALL have port clk, input, 1 bit, the sole clock, rising edge.
REQ-006 The block SHALL have port rstn, input, 1 bit, synchronous active-low reset.
REQ-007 The block SHALL have port flush, input, 1 bit, synchronous discard of all entries.
REQ-008 The block SHALL have port in_valid, input, 1 bit, producer offers in_data.
REQ-009 The block SHALL have port in_ready, output, 1 bit, queue accepts this cycle.
REQ-010 The block SHALL have port in_data, input, WIDTH bits, request word.
REQ-011 The block SHALL have port out_valid, output, 1 bit, head entry available.
REQ-012 The block SHALL have port out_ready, input, 1 bit, consumer takes the head.
REQ-013 The block SHALL have port out_data, output, WIDTH bits, head word.
REQ-014 The block SHALL have port count, output, $clog2(DEPTH)+1 bits, current occupancy.

Function
REQ-015 A push SHALL occur when in_valid and in_ready are both 1 at a rising edge.
REQ-016 A pop SHALL occur when out_valid and out_ready are both 1 at a rising edge.
REQ-017 in_ready SHALL equal (count != DEPTH).
- Full: push blocked even if a pop occurs in the same cycle.
- No combinational path from out_ready to in_ready.
REQ-018 out_valid SHALL equal (count != 0), except as extended by REQ-028.
REQ-019 The queue SHALL be first-word fall-through: out_data SHALL show the oldest entry combinationally while out_valid is 1.
REQ-020 When empty, out_data SHALL hold the last popped word.
- Before the first pop after reset or flush, it SHALL hold RST_VAL.
REQ-021 Storage SHALL be a circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-022 count SHALL be updated as follows:
- push only: +1;
- pop only: -1;
- push and pop in the same cycle: unchanged, both pointers advance;
- count SHALL never exceed DEPTH or underflow.
REQ-023 flush SHALL have priority over push and pop in the same cycle.
- Pointers and count go to 0.
- The out_data hold register goes to RST_VAL.
- A concurrent push or pop is discarded.
REQ-024 Latency without bypass SHALL be one cycle: a word pushed at edge N is visible on out_data with out_valid=1 after edge N.
REQ-025 Storage entries themselves SHALL NOT be reset; only pointers, count and the hold register SHALL be reset.

Reset
REQ-026 When rstn=0 at a rising edge, the block SHALL take the following values, with rstn taking priority over flush and handshakes:
- pointers=0 and count=0;
- out_valid=0 and in_ready=1;
- out_data=RST_VAL.
REQ-027 Reset asserted mid-transfer SHALL drop all queued entries, with no partial word retained.

Configuration
REQ-028 With macro REQ_QUEUE_BYPASS_EN defined, when count==0 and in_valid=1:
- out_valid SHALL be 1 and out_data SHALL equal in_data combinationally;
- if out_ready=1 as well, the word SHALL pass through without being stored, count SHALL stay 0 and the hold register SHALL capture in_data.
REQ-029 With REQ_QUEUE_BYPASS_EN undefined, no combinational path from in_* to out_* SHALL exist and REQ-024 latency SHALL apply.

Verification
REQ-030 Reset: hold rstn=0 for 2 cycles -> out_data=32'h1C00_0000, count=0, out_valid=0, in_ready=1.
REQ-031 Fill and drain, DEPTH=4: push 0x10,0x20,0x30,0x40 with out_ready=0 -> count=4, in_ready=0; a fifth push is refused; then out_ready=1 -> pops in order 0x10..0x40; afterwards out_data holds 0x40 and out_valid=0.
REQ-032 Wrap and simultaneous traffic: run 10 cycles of continuous push and pop at count=2 -> count stays 2 and the output order matches the input order across pointer wrap.
REQ-033 Flush priority: with count=3, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_data=RST_VAL, and the pushed word never appears.
REQ-034 Bypass, with macro defined: empty queue, in_valid=1, in_data=0xABCD, out_ready=1 -> same cycle out_valid=1 and out_data=0xABCD; count stays 0. With the macro undefined, the same stimulus gives out_valid=0 in that cycle and the word appears one cycle later.
